// File: rtl/oyun_kontrol.sv
// Pacman game sequencer: round/life/level FSM, movement gating, board and sprite
// reset pulses, dot countdown with level-clear detection and life accounting.
module oyun_kontrol #(
    parameter int DOT_COUNT   = 100,
    parameter int LIVES       = 3,
    parameter int READY_TICKS = 120,
    parameter int DEATH_TICKS = 90,
    parameter int CLEAR_TICKS = 120,
    parameter int MAX_LEVEL   = 15
) (
    input  logic       clk_i,
    input  logic       reset,
    input  logic       start_btn_i,
    input  logic       tick_i,
    input  logic       dot_eaten_i,
    input  logic       ghost_hit_i,
    output logic [2:0] state_o,
    output logic       move_en_o,
    output logic       board_reset_o,
    output logic       pos_reset_o,
    output logic [1:0] lives_o,
    output logic [3:0] level_o,
    output logic [6:0] dots_left_o,
    output logic [7:0] countdown_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        PLAY  = 3'd2,
        DEATH = 3'd3,
        CLEAR = 3'd4,
        OVER  = 3'd5
    } state_t;

    localparam logic [6:0] DOTS_INIT  = 7'(DOT_COUNT);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [3:0] LEVEL_MAX  = 4'(MAX_LEVEL);
    localparam logic [7:0] T_READY    = 8'(READY_TICKS);
    localparam logic [7:0] T_DEATH    = 8'(DEATH_TICKS);
    localparam logic [7:0] T_CLEAR    = 8'(CLEAR_TICKS);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] lives_q, lives_d;
    logic [3:0] level_q, level_d;
    logic [6:0] dots_q, dots_d;
    logic       move_q, move_d;
    logic       board_q, board_d;
    logic       pos_q, pos_d;
    logic       start_prev_q;
    logic       start_edge;
    logic       expire;

    assign start_edge = start_btn_i && !start_prev_q;
    // Treat a zero timer as expired too so a timed state can never stall.
    assign expire     = tick_i && (timer_q <= 8'd1);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        lives_d = lives_q;
        level_d = level_q;
        dots_d  = dots_q;
        board_d = 1'b0;
        pos_d   = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (start_edge) begin
                    state_d = READY;
                    timer_d = T_READY;
                    lives_d = LIVES_INIT;
                    level_d = 4'd1;
                    dots_d  = DOTS_INIT;
                    board_d = 1'b1;
                    pos_d   = 1'b1;
                end
            end
            READY: begin
                if (expire) begin
                    state_d = PLAY;
                    timer_d = 8'd0;
                end else if (tick_i) begin
                    timer_d = timer_q - 8'd1;
                end
            end
            PLAY: begin
                if (dot_eaten_i && dots_q != 7'd0)
                    dots_d = dots_q - 7'd1;
                // Eating the last dot wins over a simultaneous ghost hit.
                if (dot_eaten_i && dots_q == 7'd1) begin
                    state_d = CLEAR;
                    timer_d = T_CLEAR;
                end else if (ghost_hit_i) begin
                    state_d = DEATH;
                    timer_d = T_DEATH;
                    lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                end
            end
            DEATH: begin
                if (expire) begin
                    if (lives_q == 2'd0) begin
                        state_d = OVER;
                        timer_d = 8'd0;
                    end else begin
                        state_d = READY;
                        timer_d = T_READY;
                        pos_d   = 1'b1;
                    end
                end else if (tick_i) begin
                    timer_d = timer_q - 8'd1;
                end
            end
            CLEAR: begin
                if (expire) begin
                    state_d = READY;
                    timer_d = T_READY;
                    level_d = (level_q >= LEVEL_MAX) ? LEVEL_MAX : level_q + 4'd1;
                    dots_d  = DOTS_INIT;
                    board_d = 1'b1;
                    pos_d   = 1'b1;
                end else if (tick_i) begin
                    timer_d = timer_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = 8'd0;
            end
        endcase
        move_d = (state_d == PLAY);
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= 8'd0;
            lives_q      <= LIVES_INIT;
            level_q      <= 4'd1;
            dots_q       <= DOTS_INIT;
            move_q       <= 1'b0;
            board_q      <= 1'b0;
            pos_q        <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            dots_q       <= dots_d;
            move_q       <= move_d;
            board_q      <= board_d;
            pos_q        <= pos_d;
            start_prev_q <= start_btn_i;
        end
    end

    assign state_o       = state_q;
    assign move_en_o     = move_q;
    assign board_reset_o = board_q;
    assign pos_reset_o   = pos_q;
    assign lives_o       = lives_q;
    assign level_o       = level_q;
    assign dots_left_o   = dots_q;
    assign countdown_o   = timer_q;

endmodule

// File: tb/tb_oyun_kontrol.sv
// Directed bench for oyun_kontrol with small board/timer parameters and
// hand-computed expected values at each step.
module tb_oyun_kontrol;

    logic       clk_i = 1'b0;
    logic       reset, start_btn_i, tick_i, dot_eaten_i, ghost_hit_i;
    logic [2:0] state_o;
    logic       move_en_o, board_reset_o, pos_reset_o;
    logic [1:0] lives_o;
    logic [3:0] level_o;
    logic [6:0] dots_left_o;
    logic [7:0] countdown_o;

    int tests = 0;
    int fails = 0;

    localparam int S_IDLE = 0, S_READY = 1, S_PLAY = 2, S_DEATH = 3, S_CLEAR = 4, S_OVER = 5;

    oyun_kontrol #(
        .DOT_COUNT(3), .LIVES(2), .READY_TICKS(2), .DEATH_TICKS(2),
        .CLEAR_TICKS(2), .MAX_LEVEL(2)
    ) dut (
        .clk_i(clk_i), .reset(reset), .start_btn_i(start_btn_i), .tick_i(tick_i),
        .dot_eaten_i(dot_eaten_i), .ghost_hit_i(ghost_hit_i), .state_o(state_o),
        .move_en_o(move_en_o), .board_reset_o(board_reset_o), .pos_reset_o(pos_reset_o),
        .lives_o(lives_o), .level_o(level_o), .dots_left_o(dots_left_o),
        .countdown_o(countdown_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full output snapshot: state, move_en, board_reset, pos_reset, lives, level, dots, countdown.
    task automatic chk_all(input string tag, input int st, input int mv, input int br,
                           input int pr, input int lv, input int lvl, input int dl, input int cd);
        chk({tag, ".state"}, int'(state_o), st);
        chk({tag, ".move_en"}, int'(move_en_o), mv);
        chk({tag, ".board_reset"}, int'(board_reset_o), br);
        chk({tag, ".pos_reset"}, int'(pos_reset_o), pr);
        chk({tag, ".lives"}, int'(lives_o), lv);
        chk({tag, ".level"}, int'(level_o), lvl);
        chk({tag, ".dots"}, int'(dots_left_o), dl);
        chk({tag, ".countdown"}, int'(countdown_o), cd);
    endtask

    task automatic ticks(input int n);
        tick_i = 1'b1;
        for (int i = 0; i < n; i++) step();
        tick_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start_btn_i = 1'b1; tick_i = 1'b0;
        dot_eaten_i = 1'b0; ghost_hit_i = 1'b0;
        step(); step(); step();
        chk_all("reset", S_IDLE, 0, 0, 0, 2, 1, 3, 0);

        // Button held through reset and released as reset drops: no start.
        reset = 1'b0; start_btn_i = 1'b0;
        step(); step();
        chk("held_btn_idle", int'(state_o), S_IDLE);

        start_btn_i = 1'b1; step();
        chk_all("start", S_READY, 0, 1, 1, 2, 1, 3, 2);
        start_btn_i = 1'b0; step();
        chk_all("start_pulse_end", S_READY, 0, 0, 0, 2, 1, 3, 2);

        ticks(1);
        chk("ready_cd1", int'(countdown_o), 1);
        dot_eaten_i = 1'b1; step(); dot_eaten_i = 1'b0;
        chk("ready_dot_ignored", int'(dots_left_o), 3);
        ticks(1);
        chk_all("play1", S_PLAY, 1, 0, 0, 2, 1, 3, 0);

        start_btn_i = 1'b1; step(); start_btn_i = 1'b0; step();
        chk("play_start_ignored", int'(state_o), S_PLAY);

        // Level clear.
        dot_eaten_i = 1'b1;
        step(); chk("dots_2", int'(dots_left_o), 2);
        step(); chk("dots_1", int'(dots_left_o), 1);
        step(); dot_eaten_i = 1'b0;
        chk_all("clear", S_CLEAR, 0, 0, 0, 2, 1, 0, 2);
        ticks(1); chk("clear_cd1", int'(countdown_o), 1);
        ticks(1);
        chk_all("clear_exit", S_READY, 0, 1, 1, 2, 2, 3, 2);
        ticks(2);
        chk_all("play2", S_PLAY, 1, 0, 0, 2, 2, 3, 0);

        // Death, held ghost re-triggers on first PLAY cycle, game over.
        ghost_hit_i = 1'b1; step();
        chk_all("death1", S_DEATH, 0, 0, 0, 1, 2, 3, 2);
        dot_eaten_i = 1'b1; step(); dot_eaten_i = 1'b0;
        chk("death_dot_ignored", int'(dots_left_o), 3);
        chk("death_ghost_ignored", int'(lives_o), 1);
        ticks(2);
        chk_all("death_exit", S_READY, 0, 0, 1, 1, 2, 3, 2);
        ticks(2);
        chk_all("play_rehit", S_PLAY, 1, 0, 0, 1, 2, 3, 0);
        step();
        chk_all("death2", S_DEATH, 0, 0, 0, 0, 2, 3, 2);
        ghost_hit_i = 1'b0;
        ticks(2);
        chk_all("over", S_OVER, 0, 0, 0, 0, 2, 3, 0);
        step();
        chk("over_stays", int'(state_o), S_OVER);
        start_btn_i = 1'b1; step(); start_btn_i = 1'b0;
        chk_all("restart", S_READY, 0, 1, 1, 2, 1, 3, 2);

        // Last dot and ghost hit together: clear wins.
        ticks(2);
        dot_eaten_i = 1'b1; step(); step();
        chk("dots_before_simul", int'(dots_left_o), 1);
        ghost_hit_i = 1'b1; step();
        dot_eaten_i = 1'b0; ghost_hit_i = 1'b0;
        chk_all("simul", S_CLEAR, 0, 0, 0, 2, 1, 0, 2);
        ticks(2);
        chk("level_2", int'(level_o), 2);

        // Clear at MAX_LEVEL saturates.
        ticks(2);
        dot_eaten_i = 1'b1; step(); step(); step(); dot_eaten_i = 1'b0;
        chk("clear_at_max", int'(state_o), S_CLEAR);
        ticks(2);
        chk_all("level_sat", S_READY, 0, 1, 1, 2, 2, 3, 2);

        // Reset in DEATH with countdown 1.
        ticks(2);
        ghost_hit_i = 1'b1; step(); ghost_hit_i = 1'b0;
        ticks(1);
        chk_all("pre_reset", S_DEATH, 0, 0, 0, 1, 2, 3, 1);
        reset = 1'b1; tick_i = 1'b1; step(); tick_i = 1'b0;
        chk_all("mid_reset", S_IDLE, 0, 0, 0, 2, 1, 3, 0);
        reset = 1'b0;
        dot_eaten_i = 1'b1; step(); dot_eaten_i = 1'b0;
        chk_all("idle_dot", S_IDLE, 0, 0, 0, 2, 1, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
